// File: rtl/alu_ctrl_exec_if.sv
// EX-stage ALU handshake bundle.
// Operation request in, registered result and HI/LO out.
interface alu_ctrl_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, alu_op, funct, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal,
    input  alu_ctrl, hi, lo
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal,
    output alu_ctrl, hi, lo
  );
endinterface

// File: rtl/alu_ctrl_exec.sv
// ALU control decode + execute with iterative MULTU/DIVU.
// Results are registered and held under a valid/ready handshake.
module alu_ctrl_exec #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input logic             clk,
  input logic             reset,
  alu_ctrl_exec_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [3:0] {
    C_AND   = 4'b0000,
    C_OR    = 4'b0001,
    C_ADD   = 4'b0010,
    C_XOR   = 4'b0011,
    C_SUB   = 4'b0110,
    C_SLT   = 4'b0111,
    C_SLTU  = 4'b1000,
    C_MULTU = 4'b1001,
    C_DIVU  = 4'b1010,
    C_MFHI  = 4'b1011,
    C_NOR   = 4'b1100,
    C_MFLO  = 4'b1101,
    C_ILL   = 4'b1111
  } ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               illegal_q;
  ctrl_e              ctrl_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  ctrl_e              dec;
  logic [WIDTH-1:0]   alu_res;
  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic               is_div;
  logic               last;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_dif;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  assign in_ready = (state_q == IDLE) &&
                    (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = (dec == C_MULTU);
  assign is_div   = (dec == C_DIVU) && (bus.b != '0);
  assign last     = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    dec = C_ILL;
    unique case (bus.alu_op)
      2'b00: dec = C_ADD;
      2'b01: dec = C_SUB;
      2'b10: begin
        case (bus.funct)
          6'b100000: dec = C_ADD;
          6'b100010: dec = C_SUB;
          6'b100100: dec = C_AND;
          6'b100101: dec = C_OR;
          6'b100110: dec = C_XOR;
          6'b100111: dec = C_NOR;
          6'b101010: dec = C_SLT;
          6'b101011: dec = C_SLTU;
          6'b011001: dec = C_MULTU;
          6'b011011: dec = C_DIVU;
          6'b010000: dec = C_MFHI;
          6'b010010: dec = C_MFLO;
          default:   dec = C_ILL;
        endcase
      end
      default: dec = C_ILL;
    endcase
    if (!MULDIV_EN &&
        (dec == C_MULTU || dec == C_DIVU ||
         dec == C_MFHI  || dec == C_MFLO))
      dec = C_ILL;
  end

  always_comb begin
    alu_res = '0;
    case (dec)
      C_ADD:  alu_res = bus.a + bus.b;
      C_SUB:  alu_res = bus.a - bus.b;
      C_AND:  alu_res = bus.a & bus.b;
      C_OR:   alu_res = bus.a | bus.b;
      C_XOR:  alu_res = bus.a ^ bus.b;
      C_NOR:  alu_res = ~(bus.a | bus.b);
      C_SLT:  alu_res[0] = $signed(bus.a) < $signed(bus.b);
      C_SLTU: alu_res[0] = bus.a < bus.b;
      C_MFHI: alu_res = hi_q;
      C_MFLO: alu_res = lo_q;
      C_DIVU: alu_res = '1;
      default: alu_res = '0;
    endcase
  end

  // Shift-add: multiplier sits in the low half, shifted out LSB first.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  // Restoring divide: remainder high, quotient shifts in low.
  assign div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_dif  = div_sh - {1'b0, opnd_q};
  assign div_next = div_dif[WIDTH] ?
    {div_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0} :
    {div_dif[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && is_mul)      state_d = MUL;
        else if (accept && is_div) state_d = DIV;
      end
      MUL:     if (last) state_d = DONE;
      DIV:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      prod_q    <= '0;
      opnd_q    <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      ctrl_q    <= C_AND;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (accept) begin
      ctrl_q <= dec;
      cnt_q  <= '0;
      if (is_mul) begin
        prod_q  <= {{WIDTH{1'b0}}, bus.b};
        opnd_q  <= bus.a;
        valid_q <= 1'b0;
      end else if (is_div) begin
        prod_q  <= {{WIDTH{1'b0}}, bus.a};
        opnd_q  <= bus.b;
        valid_q <= 1'b0;
      end else begin
        valid_q   <= 1'b1;
        result_q  <= alu_res;
        zero_q    <= (alu_res == '0);
        illegal_q <= (dec == C_ILL);
        if (dec == C_DIVU) begin
          hi_q <= bus.a;
          lo_q <= '1;
        end
      end
    end else begin
      if (bus.out_ready) valid_q <= 1'b0;
      case (state_q)
        MUL: begin
          prod_q <= mul_next;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        DIV: begin
          prod_q <= div_next;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          hi_q      <= prod_q[2*WIDTH-1:WIDTH];
          lo_q      <= prod_q[WIDTH-1:0];
          result_q  <= prod_q[WIDTH-1:0];
          zero_q    <= (prod_q[WIDTH-1:0] == '0);
          illegal_q <= 1'b0;
          valid_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Scoreboard bench for alu_ctrl_exec: directed plan cases
// followed by randomized traffic against an arithmetic model.
module tb_alu_ctrl_exec;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         ill;
    logic [3:0]   ctrl;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           acc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rdy_mode = 1;
  bit   seen = 1'b0;
  exp_t q[$];
  logic [W-1:0] mh = '0;
  logic [W-1:0] ml = '0;

  alu_ctrl_exec_if #(.WIDTH(W)) bus ();

  alu_ctrl_exec #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.out_ready = ($urandom_range(0, 3) != 0);
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               n, act, exp, cyc);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       output exp_t e);
    logic [2*W-1:0] p;
    e.res = '0; e.ill = 1'b0; e.ctrl = 4'hF; e.lat = 1; e.acc = 0;
    if (op == 2'd0) begin e.res = x + y; e.ctrl = 4'h2; end
    else if (op == 2'd1) begin e.res = x - y; e.ctrl = 4'h6; end
    else if (op == 2'd2) begin
      case (f)
        6'h20: begin e.res = x + y;    e.ctrl = 4'h2; end
        6'h22: begin e.res = x - y;    e.ctrl = 4'h6; end
        6'h24: begin e.res = x & y;    e.ctrl = 4'h0; end
        6'h25: begin e.res = x | y;    e.ctrl = 4'h1; end
        6'h26: begin e.res = x ^ y;    e.ctrl = 4'h3; end
        6'h27: begin e.res = ~(x | y); e.ctrl = 4'hC; end
        6'h2A: begin
          e.res = ($signed(x) < $signed(y)) ? 1 : 0;
          e.ctrl = 4'h7;
        end
        6'h2B: begin e.res = (x < y) ? 1 : 0; e.ctrl = 4'h8; end
        6'h19: begin
          p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
          mh = p[2*W-1:W]; ml = p[W-1:0];
          e.res = ml; e.ctrl = 4'h9; e.lat = W + 2;
        end
        6'h1B: begin
          if (y == 0) begin ml = '1; mh = x; end
          else begin ml = x / y; mh = x % y; e.lat = W + 2; end
          e.res = ml; e.ctrl = 4'hA;
        end
        6'h10: begin e.res = mh; e.ctrl = 4'hB; end
        6'h12: begin e.res = ml; e.ctrl = 4'hD; end
        default: e.ctrl = 4'hF;
      endcase
    end
    e.ill = (e.ctrl == 4'hF);
    e.hi = mh; e.lo = ml;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   t;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = op; bus.funct = f;
    bus.a = x; bus.b = y;
    t = 0;
    forever begin
      #1;
      if (bus.in_ready) break;
      t++;
      if (t > 200) begin
        chk("accept_timeout", 64'(t), 0);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    model(op, f, x, y, e);
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    bus.funct = 6'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(q.size()), 0);
  endtask

  // Monitor: compare the head entry on every cycle it is presented.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat - 1));
            seen = 1'b1;
          end
          chk("result",   bus.result,   q[0].res);
          chk("zero",     bus.zero,     q[0].res == 0);
          chk("illegal",  bus.illegal,  q[0].ill);
          chk("alu_ctrl", bus.alu_ctrl, q[0].ctrl);
          chk("hi",       bus.hi,       q[0].hi);
          chk("lo",       bus.lo,       q[0].lo);
          if (bus.out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  logic [7:0] optab [0:13] = '{
    {2'b00, 6'h00}, {2'b01, 6'h00}, {2'b11, 6'h00},
    {2'b10, 6'h20}, {2'b10, 6'h22}, {2'b10, 6'h24},
    {2'b10, 6'h25}, {2'b10, 6'h26}, {2'b10, 6'h27},
    {2'b10, 6'h2A}, {2'b10, 6'h2B}, {2'b10, 6'h19},
    {2'b10, 6'h1B}, {2'b10, 6'h10}
  };

  initial begin
    int t;
    logic [7:0]   sel;
    logic [W-1:0] x;
    logic [W-1:0] y;
    bus.in_valid = 1'b0; bus.alu_op = '0; bus.funct = '0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result",    bus.result,    0);
    chk("rst_zero",      bus.zero,      1);
    chk("rst_illegal",   bus.illegal,   0);
    chk("rst_alu_ctrl",  bus.alu_ctrl,  0);
    chk("rst_hi",        bus.hi,        0);
    chk("rst_lo",        bus.lo,        0);
    rst = 1'b0;

    issue(2'b10, 6'h20, 5, 7);
    issue(2'b10, 6'h2A, 32'hFFFF_FFFF, 1);
    issue(2'b10, 6'h2B, 32'hFFFF_FFFF, 1);
    issue(2'b01, 6'h00, 9, 9);
    drain();

    issue(2'b10, 6'h19, 32'hFFFF_FFFF, 2);
    t = 0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.in_ready || t > 100) break;
      t++;
    end
    chk("mul_stall_cycles", 64'(t), 64'(W + 1));
    issue(2'b10, 6'h10, 0, 0);
    issue(2'b10, 6'h12, 0, 0);
    issue(2'b10, 6'h1B, 100, 7);
    issue(2'b10, 6'h1B, 5, 0);
    issue(2'b10, 6'h10, 0, 0);
    drain();

    rdy_mode = 2;
    issue(2'b10, 6'h20, 32'h1234, 32'h4321);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_in_ready", bus.in_ready, 0);
    end
    rdy_mode = 1;
    issue(2'b10, 6'h3F, 3, 4);
    drain();

    issue(2'b10, 6'h19, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
    repeat (9) @(negedge clk);
    #1;
    rst = 1'b1;
    q.delete(); seen = 1'b0; mh = '0; ml = '0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_result",    bus.result,    0);
    chk("arst_zero",      bus.zero,      1);
    chk("arst_hi",        bus.hi,        0);
    chk("arst_lo",        bus.lo,        0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    issue(2'b10, 6'h20, 40, 2);
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 200; i++) begin
      sel = ($urandom_range(0, 9) == 0) ?
            {2'b10, 6'($urandom)} : optab[$urandom_range(0, 13)];
      x = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) : $urandom;
      y = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) : $urandom;
      if (sel[5:0] == 6'h1B && $urandom_range(0, 4) == 0) y = '0;
      issue(sel[7:6], sel[5:0], x, y);
      if ($urandom_range(0, 4) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rdy_mode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_exec.md
Name: alu_ctrl_exec

Overview:
Parametrised successor to the single-cycle ALU control decoder. Decodes ALUOp/funct into an internal ALU operation and executes it. Supports single-cycle logic/arithmetic ops plus iterative unsigned multiply/divide with HI/LO registers. Sits in the EX stage behind a valid/ready handshake so the pipeline can stall on multi-cycle ops.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
MULDIV_EN, 1, 1 = MULTU/DIVU/MFHI/MFLO implemented; 0 = those functs flagged illegal
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operation presented
in_ready  out  1  unit can accept this cycle
alu_op  in  2  00 ADD (lw/sw), 01 SUB (beq), 10 R-type (use funct), 11 reserved
funct  in  6  instruction funct field
a  in  WIDTH  operand rs
b  in  WIDTH  operand rt
out_valid  out  1  result registered and held
out_ready  in  1  consumer takes result
result  out  WIDTH  operation result
zero  out  1  result == 0
illegal  out  1  accepted op was undecodable (qualifies out_valid)
alu_ctrl  out  4  decoded op code of the accepted op (debug)
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async): state IDLE; out_valid=0, result=0, zero=1, illegal=0, alu_ctrl=0, hi=0, lo=0, counter=0.
- Accept: in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Decode (alu_ctrl): ADD=0010, SUB=0110, AND=0000, OR=0001, XOR=0011, NOR=1100, SLT=0111, SLTU=1000, MULTU=1001, DIVU=1010, MFHI=1011, MFLO=1101, ILL=1111.
- alu_op 00->ADD, 01->SUB, 11->ILL. alu_op 10 functs: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT (signed), 101011 SLTU, 011001 MULTU, 011011 DIVU, 010000 MFHI, 010010 MFLO; any other funct -> ILL. With MULDIV_EN=0 the last four -> ILL.
- ADD/SUB wrap modulo 2^WIDTH, no overflow trap. SLT/SLTU result = {WIDTH-1 zeros, flag}.
- Single-cycle ops (incl. MFHI/MFLO/ILL): result registered, out_valid=1 on the cycle after accept (latency 1). ILL: result=0, illegal=1.
- States: IDLE, MUL, DIV, DONE. MULTU: IDLE->MUL, shift-add, one bit/cycle, WIDTH cycles, then {hi,lo}=a*b (2*WIDTH product); DIVU: IDLE->DIV, restoring divide, WIDTH cycles, lo=quotient, hi=remainder. Iterations end -> DONE for 1 cycle, which sets out_valid with result=lo -> IDLE. Latency accept-to-out_valid = WIDTH+2 cycles.
- DIVU b==0: no iteration; lo=all ones, hi=a, out_valid after 1 cycle.
- hi/lo update only at MULTU/DIVU completion; MFHI/MFLO issued right after read the new values.
- Output holds (result, zero, illegal, alu_ctrl stable) while out_valid && !out_ready. out_valid clears on out_ready unless a new accept occurs that cycle (then it reloads next cycle for single-cycle ops; the same-cycle handoff is allowed by in_ready).
- Inputs ignored while state != IDLE; operands latched at accept, so later changes to a/b/funct have no effect.
- Reset during MUL/DIV aborts immediately; hi/lo return to 0; no out_valid.

Test Plan:
- alu_op=10, funct=100000, a=5, b=7 -> next cycle out_valid=1, result=12, zero=0, alu_ctrl=0010.
- alu_op=10, funct=101010, a=0xFFFFFFFF, b=1 -> result=1; same with funct=101011 -> result=0; alu_op=01, a=b=9 -> result=0, zero=1.
- MULTU a=0xFFFFFFFF, b=2 -> in_ready=0 for 33 cycles; out_valid after 34 cycles with hi=1, lo=0xFFFFFFFE; then MFHI -> result=1.
- DIVU a=100, b=7 -> lo=14, hi=2 after 34 cycles; DIVU b=0, a=5 -> lo=0xFFFFFFFF, hi=5 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after ADD -> result held, in_ready=0; funct=111111 -> illegal=1, result=0.
- Reset asserted mid-MULTU (cycle 10) -> outputs at reset values same cycle, hi=lo=0; next ADD completes normally.
